// File: rtl/keys_debounce_pulse4.sv
// keys_debounce_pulse4
// Four-channel active-low key front end: two-stage synchroniser, shared 1 ms
// tick, per-key press/release debounce FSM, single-cycle press pulse with
// optional auto-repeat while held, and a debounced pressed level.
module keys_debounce_pulse4 #(
   parameter logic [15:0] T1MS        = 16'd49_999,
   parameter logic [10:0] DEBOUNCE_MS = 11'd20,
   parameter logic [10:0] HOLD_MS     = 11'd500,
   parameter logic [10:0] REPEAT_MS   = 11'd100,
   parameter logic        REPEAT_EN   = 1'b1
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [3:0] key_in,
   output logic [3:0] key_pulse,
   output logic [3:0] key_level
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HELD      = 2'd2,
      REL_CHK   = 2'd3
   } state_t;

   // Counters hold "ticks seen so far", so the terminal check is one below the target.
   localparam logic [10:0] DEB_LAST  = DEBOUNCE_MS - 11'd1;
   localparam logic [10:0] HOLD_LAST = HOLD_MS - 11'd1;
   localparam logic [10:0] REP_LAST  = REPEAT_MS - 11'd1;

   logic [3:0]  sync1;
   logic [3:0]  sync2;
   logic [3:0]  key_s;

   logic [15:0] tick_cnt;
   logic        tick;

   state_t      state     [4];
   state_t      state_nxt [4];
   logic [10:0] cnt       [4];
   logic [10:0] cnt_nxt   [4];
   logic [3:0]  rep;
   logic [3:0]  rep_nxt;

   logic [3:0]  pulse_nxt;
   logic [3:0]  level_nxt;

   // Two-flop synchroniser; resets to released (1) so no false press after reset.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   assign key_s = ~sync2;

   // Free-running 1 ms time base shared by all keys; never restarted by key activity.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   assign tick = (tick_cnt == T1MS);

   // Per-key state register: FSM state, ms counter and repeat-phase flag.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int unsigned i = 0; i < 4; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
         rep <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
         rep <= rep_nxt;
      end
   end

   // Per-key next-state, counter and repeat-phase decode.
   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = cnt[i];
         rep_nxt[i]   = rep[i];
         case (state[i])
            IDLE: begin
               if (key_s[i]) begin
                  state_nxt[i] = PRESS_CHK;
                  cnt_nxt[i]   = '0;
               end
            end
            PRESS_CHK: begin
               if (!key_s[i]) begin
                  state_nxt[i] = IDLE;
               end else if (tick) begin
                  if (cnt[i] == DEB_LAST) begin
                     state_nxt[i] = HELD;
                     cnt_nxt[i]   = '0;
                     rep_nxt[i]   = 1'b0;
                  end else begin
                     cnt_nxt[i] = cnt[i] + 11'd1;
                  end
               end
            end
            HELD: begin
               if (!key_s[i]) begin
                  state_nxt[i] = REL_CHK;
                  cnt_nxt[i]   = '0;
               end else if (tick && REPEAT_EN) begin
                  // With repeat disabled the counter is frozen so it can never wrap.
                  if (cnt[i] == (rep[i] ? REP_LAST : HOLD_LAST)) begin
                     cnt_nxt[i] = '0;
                     rep_nxt[i] = 1'b1;
                  end else begin
                     cnt_nxt[i] = cnt[i] + 11'd1;
                  end
               end
            end
            REL_CHK: begin
               if (key_s[i]) begin
                  state_nxt[i] = HELD;
                  cnt_nxt[i]   = '0;
               end else if (tick) begin
                  if (cnt[i] == DEB_LAST) begin
                     state_nxt[i] = IDLE;
                     cnt_nxt[i]   = '0;
                  end else begin
                     cnt_nxt[i] = cnt[i] + 11'd1;
                  end
               end
            end
            default: begin
               state_nxt[i] = IDLE;
               cnt_nxt[i]   = '0;
            end
         endcase
      end
   end

   // Output decode: pulse on accepted press or repeat, level follows the held states.
   always_comb begin
      pulse_nxt = '0;
      level_nxt = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         case (state[i])
            PRESS_CHK: pulse_nxt[i] = key_s[i] & tick & (cnt[i] == DEB_LAST);
            HELD:      pulse_nxt[i] = key_s[i] & tick & REPEAT_EN &
                                      (cnt[i] == (rep[i] ? REP_LAST : HOLD_LAST));
            default:   pulse_nxt[i] = 1'b0;
         endcase
         level_nxt[i] = (state_nxt[i] == HELD) || (state_nxt[i] == REL_CHK);
      end
   end

   // Output registers: pulse and level change on the same edge as the FSM.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         key_pulse <= '0;
         key_level <= '0;
      end else begin
         key_pulse <= pulse_nxt;
         key_level <= level_nxt;
      end
   end

endmodule

// File: tb/tb_keys_debounce_pulse4.sv
// Bench for keys_debounce_pulse4: two instances (repeat on / repeat off) share
// stimulus; a timestamp-based reference model predicts both every cycle, and
// directed phases check latency windows, bounce rejection and repeat spacing.
module tb_keys_debounce_pulse4;

   localparam int T = 9;
   localparam int D = 3;
   localparam int H = 10;
   localparam int R = 4;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic [3:0] key_in = 4'hF;
   logic [3:0] pa, la, pb, lb;

   keys_debounce_pulse4 #(
      .T1MS(16'd9), .DEBOUNCE_MS(11'd3), .HOLD_MS(11'd10), .REPEAT_MS(11'd4), .REPEAT_EN(1'b1)
   ) dut_a (
      .CLK(CLK), .RSTn(RSTn), .key_in(key_in), .key_pulse(pa), .key_level(la)
   );

   keys_debounce_pulse4 #(
      .T1MS(16'd9), .DEBOUNCE_MS(11'd3), .HOLD_MS(11'd10), .REPEAT_MS(11'd4), .REPEAT_EN(1'b0)
   ) dut_b (
      .CLK(CLK), .RSTn(RSTn), .key_in(key_in), .key_pulse(pb), .key_level(lb)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // Reference model: edges counted from reset release; a tick lands on every
   // edge that is a multiple of T+1. Channels 0..3 model dut_a, 4..7 dut_b.
   int         edge_n;
   logic [3:0] hist[$];
   bit         lvl[8];
   bit         dv[8];
   bit         rp[8];
   int         run_start[8];
   int         hold_ref[8];
   logic [3:0] exp_pa, exp_la, exp_pb, exp_lb;

   int         npa[4];
   int         npb[4];
   int         q2[$];

   function automatic int ticks_between(input int a, input int b);
      return b / (T + 1) - a / (T + 1);
   endfunction

   task automatic model_reset();
      edge_n = 0;
      hist.delete();
      for (int c = 0; c < 8; c++) begin
         lvl[c] = 0; dv[c] = 0; rp[c] = 0; run_start[c] = 0; hold_ref[c] = 0;
      end
      exp_pa = '0; exp_la = '0; exp_pb = '0; exp_lb = '0;
   endtask

   task automatic model_step();
      logic [3:0] s4;
      bit tk, s, p, ren;
      int k;
      edge_n++;
      hist.push_front(key_in);
      if (hist.size() > 3) void'(hist.pop_back());
      s4 = (hist.size() >= 3) ? ~hist[2] : 4'b0000;
      tk = (edge_n % (T + 1) == 0);
      exp_pa = '0; exp_pb = '0;
      for (int c = 0; c < 8; c++) begin
         k = c % 4;
         s = s4[k];
         ren = (c < 4);
         p = 0;
         if (s != lvl[c]) begin
            if (!dv[c]) run_start[c] = edge_n;
            else if (tk && ticks_between(run_start[c], edge_n) == D) begin
               lvl[c] = s;
               if (s) begin p = 1; hold_ref[c] = edge_n; rp[c] = 0; end
            end
         end else if (lvl[c]) begin
            if (dv[c]) hold_ref[c] = edge_n;
            else if (ren && tk && ticks_between(hold_ref[c], edge_n) == (rp[c] ? R : H)) begin
               p = 1; hold_ref[c] = edge_n; rp[c] = 1;
            end
         end
         dv[c] = (s != lvl[c]);
         if (c < 4) begin exp_pa[k] = p; exp_la[k] = lvl[c]; end
         else       begin exp_pb[k] = p; exp_lb[k] = lvl[c]; end
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_counts();
      for (int k = 0; k < 4; k++) begin npa[k] = 0; npb[k] = 0; end
      q2.delete();
   endtask

   // One clock: model follows the edge, DUT sampled on the falling edge.
   task automatic cyc();
      @(posedge CLK);
      if (!RSTn) model_reset(); else model_step();
      @(negedge CLK);
      chk("pulse_a", pa, exp_pa);
      chk("level_a", la, exp_la);
      chk("pulse_b", pb, exp_pb);
      chk("level_b", lb, exp_lb);
      for (int k = 0; k < 4; k++) begin
         if (pa[k] === 1'b1) begin
            npa[k]++;
            if (k == 2) q2.push_back(edge_n);
         end
         if (pb[k] === 1'b1) npb[k]++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      logic [3:0] m;
      int len;
      model_reset();
      clear_counts();

      // Reset with all keys pressed: outputs must stay low.
      RSTn = 1'b0;
      key_in = 4'b0000;
      repeat (5) begin
         cyc();
         chk("reset_pulse", pa | pb, 4'b0000);
         chk("reset_level", la | lb, 4'b0000);
      end
      RSTn = 1'b1;
      first = -1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (first < 0 && pa != 4'b0000) begin
            first = edge_n;
            chk("first_pulse_value", pa, 4'b1111);
         end
      end
      chk_int("first_pulse_window", int'(first >= 24 && first <= 34), 1);
      chk_int("first_pulse_single_a", npa[0] + npa[1] + npa[2] + npa[3], 4);
      chk_int("first_pulse_single_b", npb[0] + npb[1] + npb[2] + npb[3], 4);
      key_in = 4'hF;
      repeat (50) cyc();
      chk("all_released", la | lb, 4'b0000);

      // Press bounce on key 0.
      clear_counts();
      for (int i = 0; i < 60; i++) begin
         key_in[0] = ((i / 7) % 2 == 0) ? 1'b0 : 1'b1;
         cyc();
      end
      chk_int("press_bounce_no_pulse", npa[0], 0);
      key_in[0] = 1'b0;
      repeat (60) cyc();
      chk_int("press_bounce_one_pulse", npa[0], 1);
      chk_int("press_bounce_level", int'(la[0]), 1);
      key_in[0] = 1'b1;
      repeat (50) cyc();

      // Release bounce on key 1.
      clear_counts();
      key_in[1] = 1'b0;
      repeat (40) cyc();
      chk_int("rel_press_pulse", npa[1], 1);
      for (int j = 0; j < 8; j++) begin
         key_in[1] = (j % 2 == 0) ? 1'b1 : 1'b0;
         repeat (12) cyc();
      end
      chk_int("rel_bounce_level", int'(la[1]), 1);
      chk_int("rel_bounce_no_pulse", npa[1], 1);
      key_in[1] = 1'b1;
      repeat (20) cyc();
      chk_int("rel_level_early", int'(la[1]), 1);
      repeat (20) cyc();
      chk_int("rel_level_fall", int'(la[1]), 0);

      // Auto-repeat on key 2; dut_b has repeat disabled.
      clear_counts();
      key_in[2] = 1'b0;
      repeat (300) cyc();
      key_in[2] = 1'b1;
      repeat (50) cyc();
      chk_int("repeat_count", q2.size(), 6);
      for (int i = 1; i < 6; i++) begin
         if (i < q2.size()) chk_int("repeat_gap", q2[i] - q2[i-1], (i == 1) ? H * (T + 1) : R * (T + 1));
      end
      chk_int("norepeat_count", npb[2], 1);

      // Reset in the middle of key 3's press debounce.
      clear_counts();
      key_in[3] = 1'b0;
      repeat (18) cyc();
      chk_int("midreset_no_early", npa[3], 0);
      RSTn = 1'b0;
      repeat (3) cyc();
      RSTn = 1'b1;
      first = -1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (first < 0 && pa[3] === 1'b1) first = edge_n;
      end
      chk_int("midreset_window", int'(first >= 24 && first <= 34), 1);
      chk_int("midreset_one_pulse", npa[3], 1);
      chk_int("midreset_one_pulse_b", npb[3], 1);
      key_in[3] = 1'b1;
      repeat (50) cyc();

      // Randomised key activity, occasionally with a reset pulse.
      for (int seg = 0; seg < 200; seg++) begin
         m = 4'($urandom_range(0, 15));
         key_in = (key_in & ~m) | (4'($urandom_range(0, 15)) & m);
         len = $urandom_range(1, 45);
         if ($urandom_range(0, 49) == 0) begin
            RSTn = 1'b0;
            repeat (2) cyc();
            RSTn = 1'b1;
         end
         repeat (len) cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
